// File: rtl/trace_pkg.sv
// Shared AXI constants and FSM state type for the trace stream sink.
package trace_pkg;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

endpackage

// File: rtl/trace_sink_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; DEPTH must be a power of two.
module trace_sink_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout_c,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full_c,
   output logic                     empty_c
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic             do_push;
   logic             do_pop;

   assign full_c  = (count == CNT_W'(DEPTH));
   assign empty_c = (count == '0);
   assign do_push = push & ~full_c;
   assign do_pop  = pop & ~empty_c;
   assign dout_c  = mem[rd_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_idx <= wr_idx + IDX_W'(1);
         if (do_pop)  rd_idx <= rd_idx + IDX_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Payload storage carries no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_idx] <= din;
   end

endmodule

// File: rtl/trace_stream_sink.sv
// AXI-Stream trace receiver writing INCR bursts into a DRAM ring buffer.
// Define TRACE_DROP_ON_FULL_EN to drop beats on a full FIFO instead of backpressuring.
module trace_stream_sink
   import trace_pkg::*;
#(
   parameter int unsigned DATA_W    = 512,
   parameter int unsigned ADDR_W    = 36,
   parameter int unsigned BURST_LEN = 16,
   parameter int unsigned PTR_W     = 20
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  s_axis_trace_tvalid,
   output logic                  s_axis_trace_tready,
   input  logic [DATA_W-1:0]     s_axis_trace_tdata,
   input  logic [DATA_W/8-1:0]   s_axis_trace_tkeep,
   input  logic                  s_axis_trace_tlast,
   output logic [ADDR_W-1:0]     m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_W-1:0]     m_axi_wdata,
   output logic [DATA_W/8-1:0]   m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   input  logic                  cfg_enable,
   input  logic [ADDR_W-1:0]     cfg_base,
   input  logic [PTR_W-1:0]      cfg_size,
   input  logic [PTR_W-1:0]      cfg_rd_ptr,
   output logic [PTR_W-1:0]      sts_wr_ptr,
   output logic [31:0]           sts_drop_cnt,
   output logic                  sts_err,
   output logic                  sts_busy
);

   localparam int unsigned KEEP_W     = DATA_W / 8;
   localparam int unsigned FIFO_W     = DATA_W + KEEP_W + 1;
   localparam int unsigned FIFO_DEPTH = 2 * BURST_LEN;
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned LEN_W      = $clog2(BURST_LEN) + 1;
   localparam int unsigned SIZE_LOG2  = $clog2(KEEP_W);

   state_t              state;
   logic [LEN_W-1:0]    burst_len;
   logic [LEN_W-1:0]    beat_cnt;
   logic [CNT_W-1:0]    tlast_cnt;

   logic [FIFO_W-1:0]   fifo_dout_c;
   logic [CNT_W-1:0]    fifo_cnt;
   logic                fifo_full_c;
   logic                fifo_empty_c;
   logic                fifo_push_c;
   logic                fifo_pop_c;
   logic                head_last_c;
   logic                drop_c;
   logic                tready_nxt_c;

   logic [PTR_W-1:0]    used_c;
   logic [PTR_W-1:0]    free_c;
   logic [PTR_W-1:0]    ptr_sum_c;
   logic [PTR_W-1:0]    ptr_nxt_c;
   logic [LEN_W-1:0]    burst_n_c;
   logic                start_c;

   assign m_axi_awsize  = 3'(SIZE_LOG2);
   assign m_axi_awburst = BURST_INCR;
   assign m_axi_wdata   = fifo_dout_c[DATA_W-1:0];
   assign m_axi_wstrb   = fifo_dout_c[DATA_W +: KEEP_W];
   assign head_last_c   = fifo_dout_c[FIFO_W-1];

   assign fifo_push_c = s_axis_trace_tvalid & s_axis_trace_tready & ~fifo_full_c;
   assign fifo_pop_c  = m_axi_wvalid & m_axi_wready & ~fifo_empty_c;

`ifdef TRACE_DROP_ON_FULL_EN
   assign drop_c       = s_axis_trace_tvalid & s_axis_trace_tready & fifo_full_c;
   assign tready_nxt_c = cfg_enable;
`else
   logic [CNT_W-1:0] fifo_cnt_nxt_c;
   assign fifo_cnt_nxt_c = fifo_cnt + CNT_W'(fifo_push_c) - CNT_W'(fifo_pop_c);
   assign drop_c         = 1'b0;
   assign tready_nxt_c   = cfg_enable & (fifo_cnt_nxt_c != CNT_W'(FIFO_DEPTH));
`endif

   trace_sink_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (aclk),
      .rst     (areset),
      .push    (fifo_push_c),
      .din     ({s_axis_trace_tlast, s_axis_trace_tkeep, s_axis_trace_tdata}),
      .pop     (fifo_pop_c),
      .dout_c  (fifo_dout_c),
      .count   (fifo_cnt),
      .full_c  (fifo_full_c),
      .empty_c (fifo_empty_c)
   );

   // Ring occupancy, next burst size and the launch decision.
   always_comb begin
      used_c    = '0;
      free_c    = '0;
      burst_n_c = '0;
      start_c   = 1'b0;
      ptr_sum_c = '0;
      ptr_nxt_c = '0;
      if (sts_wr_ptr >= cfg_rd_ptr) used_c = sts_wr_ptr - cfg_rd_ptr;
      else                          used_c = cfg_size - cfg_rd_ptr + sts_wr_ptr;
      free_c    = cfg_size - PTR_W'(1) - used_c;
      burst_n_c = (fifo_cnt >= CNT_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(fifo_cnt);
      start_c   = ((fifo_cnt >= CNT_W'(BURST_LEN)) || (tlast_cnt != '0)) &&
                  (PTR_W'(burst_n_c) <= free_c);
      ptr_sum_c = sts_wr_ptr + PTR_W'(burst_len);
      ptr_nxt_c = (ptr_sum_c >= cfg_size) ? ptr_sum_c - cfg_size : ptr_sum_c;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state               <= IDLE;
         s_axis_trace_tready <= 1'b0;
         m_axi_awaddr        <= '0;
         m_axi_awlen         <= '0;
         m_axi_awvalid       <= 1'b0;
         m_axi_wvalid        <= 1'b0;
         m_axi_wlast         <= 1'b0;
         m_axi_bready        <= 1'b0;
         burst_len           <= '0;
         beat_cnt            <= '0;
         tlast_cnt           <= '0;
         sts_wr_ptr          <= '0;
         sts_drop_cnt        <= '0;
         sts_err             <= 1'b0;
         sts_busy            <= 1'b0;
      end else begin
         s_axis_trace_tready <= tready_nxt_c;
         tlast_cnt <= tlast_cnt + CNT_W'(fifo_push_c & s_axis_trace_tlast)
                                - CNT_W'(fifo_pop_c & head_last_c);
         sts_busy  <= (state != IDLE) || (fifo_cnt != '0);
         if (drop_c && (sts_drop_cnt != '1)) sts_drop_cnt <= sts_drop_cnt + 32'd1;

         case (state)
            IDLE: if (start_c) begin
               burst_len     <= burst_n_c;
               m_axi_awlen   <= 8'(burst_n_c - LEN_W'(1));
               m_axi_awaddr  <= cfg_base + (ADDR_W'(sts_wr_ptr) << SIZE_LOG2);
               m_axi_awvalid <= 1'b1;
               state         <= AW;
            end
            AW: if (m_axi_awready) begin
               m_axi_awvalid <= 1'b0;
               m_axi_wvalid  <= 1'b1;
               m_axi_wlast   <= (burst_len == LEN_W'(1));
               beat_cnt      <= '0;
               state         <= W;
            end
            W: if (m_axi_wready) begin
               beat_cnt <= beat_cnt + LEN_W'(1);
               if (m_axi_wlast) begin
                  m_axi_wvalid <= 1'b0;
                  m_axi_wlast  <= 1'b0;
                  m_axi_bready <= 1'b1;
                  state        <= B;
               end else begin
                  m_axi_wlast <= (beat_cnt + LEN_W'(2) == burst_len);
               end
            end
            // Pointer advances even on an error response so data is never re-sent.
            B: if (m_axi_bvalid) begin
               m_axi_bready <= 1'b0;
               if (m_axi_bresp != RESP_OKAY) sts_err <= 1'b1;
               sts_wr_ptr   <= ptr_nxt_c;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trace_stream_sink.sv
// Scoreboard bench for trace_stream_sink: AXI slave model checks every written beat in order.
`timescale 1ns/1ps
module tb_trace_stream_sink;
   import trace_pkg::*;

   localparam int unsigned DATA_W = 512;
   localparam int unsigned KEEP_W = DATA_W / 8;
   localparam int unsigned ADDR_W = 36;
   localparam int unsigned PTR_W  = 20;
   localparam logic [ADDR_W-1:0] BASE = 36'h1_0000_0000;
   localparam int TMO = 20000;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
   } beat_t;

   logic                clk = 1'b0;
   logic                areset;
   logic                s_axis_trace_tvalid, s_axis_trace_tready, s_axis_trace_tlast;
   logic [DATA_W-1:0]   s_axis_trace_tdata;
   logic [KEEP_W-1:0]   s_axis_trace_tkeep;
   logic [ADDR_W-1:0]   m_axi_awaddr;
   logic [7:0]          m_axi_awlen;
   logic [2:0]          m_axi_awsize;
   logic [1:0]          m_axi_awburst;
   logic                m_axi_awvalid, m_axi_awready;
   logic [DATA_W-1:0]   m_axi_wdata;
   logic [KEEP_W-1:0]   m_axi_wstrb;
   logic                m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic [1:0]          m_axi_bresp;
   logic                m_axi_bvalid, m_axi_bready;
   logic                cfg_enable;
   logic [ADDR_W-1:0]   cfg_base;
   logic [PTR_W-1:0]    cfg_size, cfg_rd_ptr, sw_rd_ptr;
   logic [PTR_W-1:0]    sts_wr_ptr;
   logic [31:0]         sts_drop_cnt;
   logic                sts_err, sts_busy;

   beat_t               exp_q[$];
   logic [7:0]          len_q[$];
   int                  n_tests = 0;
   int                  n_fail  = 0;
   int unsigned         model_wr;
   int                  burst_cnt;
   int                  err_at = -1;
   int                  beat_idx;
   logic [7:0]          cur_len;
   bit                  stall_en = 1'b0, auto_drain = 1'b0, pending_b, b_done;

   always #5 clk = ~clk;

   trace_stream_sink dut (
      .aclk                (clk),
      .areset              (areset),
      .s_axis_trace_tvalid (s_axis_trace_tvalid),
      .s_axis_trace_tready (s_axis_trace_tready),
      .s_axis_trace_tdata  (s_axis_trace_tdata),
      .s_axis_trace_tkeep  (s_axis_trace_tkeep),
      .s_axis_trace_tlast  (s_axis_trace_tlast),
      .m_axi_awaddr        (m_axi_awaddr),
      .m_axi_awlen         (m_axi_awlen),
      .m_axi_awsize        (m_axi_awsize),
      .m_axi_awburst       (m_axi_awburst),
      .m_axi_awvalid       (m_axi_awvalid),
      .m_axi_awready       (m_axi_awready),
      .m_axi_wdata         (m_axi_wdata),
      .m_axi_wstrb         (m_axi_wstrb),
      .m_axi_wlast         (m_axi_wlast),
      .m_axi_wvalid        (m_axi_wvalid),
      .m_axi_wready        (m_axi_wready),
      .m_axi_bresp         (m_axi_bresp),
      .m_axi_bvalid        (m_axi_bvalid),
      .m_axi_bready        (m_axi_bready),
      .cfg_enable          (cfg_enable),
      .cfg_base            (cfg_base),
      .cfg_size            (cfg_size),
      .cfg_rd_ptr          (cfg_rd_ptr),
      .sts_wr_ptr          (sts_wr_ptr),
      .sts_drop_cnt        (sts_drop_cnt),
      .sts_err             (sts_err),
      .sts_busy            (sts_busy)
   );

   task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // AXI slave: decisions made at the falling edge take effect at the next rising edge.
   initial begin
      beat_t b;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_bresp   = RESP_OKAY;
      cfg_rd_ptr    = '0;
      forever begin
         @(negedge clk);
         if (areset) begin
            m_axi_bvalid = 1'b0;
            pending_b = 1'b0; b_done = 1'b0;
            model_wr = 0; burst_cnt = 0; beat_idx = 0; cur_len = '0;
            cfg_rd_ptr = sw_rd_ptr;
         end else begin
            if (b_done) begin m_axi_bvalid = 1'b0; b_done = 1'b0; end
            m_axi_awready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_axi_wready  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (pending_b && !m_axi_bvalid && (!stall_en || $urandom_range(0, 2) == 0)) begin
               m_axi_bvalid = 1'b1;
               m_axi_bresp  = (burst_cnt == err_at) ? 2'b10 : RESP_OKAY;
            end
            if (m_axi_awvalid && m_axi_awready) begin
               check_val("awaddr", m_axi_awaddr, cfg_base + (ADDR_W'(model_wr) << 6));
               check_val("awsize", m_axi_awsize, 3'd6);
               check_val("awburst", m_axi_awburst, 2'b01);
               cur_len  = m_axi_awlen;
               beat_idx = 0;
               len_q.push_back(m_axi_awlen);
            end
            if (m_axi_wvalid && m_axi_wready) begin
               if (exp_q.size() == 0) check_val("w_unexpected", 1, 0);
               else begin
                  b = exp_q.pop_front();
                  check_val("wdata", m_axi_wdata, b.data);
                  check_val("wstrb", m_axi_wstrb, b.keep);
               end
               check_val("wlast", m_axi_wlast, beat_idx == int'(cur_len));
               if (m_axi_wlast) pending_b = 1'b1;
               beat_idx++;
            end
            if (m_axi_bvalid && m_axi_bready) begin
               b_done    = 1'b1;
               pending_b = 1'b0;
               model_wr  = (model_wr + cur_len + 1) % cfg_size;
               burst_cnt++;
            end
            cfg_rd_ptr = auto_drain ? PTR_W'(model_wr) : sw_rd_ptr;
         end
      end
   end

   task automatic send_beat(input logic last, input bit store);
      beat_t b;
      int guard;
      for (int i = 0; i < DATA_W / 32; i++) b.data[i*32 +: 32] = $urandom;
      b.keep = {$urandom, $urandom};
      @(negedge clk);
      s_axis_trace_tvalid = 1'b1;
      s_axis_trace_tdata  = b.data;
      s_axis_trace_tkeep  = b.keep;
      s_axis_trace_tlast  = last;
      guard = 0;
      while (!s_axis_trace_tready && guard < TMO) begin
         @(negedge clk);
         guard++;
      end
      if (!s_axis_trace_tready) check_val("tready_timeout", 0, 1);
      else if (store) exp_q.push_back(b);
      @(posedge clk);
      #1 s_axis_trace_tvalid = 1'b0;
   endtask

   task automatic wait_idle();
      int quiet = 0;
      int guard = 0;
      while (quiet < 8 && guard < TMO) begin
         @(negedge clk);
         guard++;
         if (exp_q.size() == 0 && !sts_busy && !m_axi_bvalid && !pending_b) quiet++;
         else quiet = 0;
      end
      if (quiet < 8) check_val("idle_timeout", 0, 1);
   endtask

   task automatic do_reset(input logic [PTR_W-1:0] size);
      @(negedge clk);
      areset    = 1'b1;
      cfg_size  = size;
      sw_rd_ptr = '0;
      exp_q.delete();
      len_q.delete();
      repeat (3) @(negedge clk);
      areset = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      areset = 1'b1;
      s_axis_trace_tvalid = 1'b0;
      s_axis_trace_tdata  = '0;
      s_axis_trace_tkeep  = '0;
      s_axis_trace_tlast  = 1'b0;
      cfg_enable = 1'b1;
      cfg_base   = BASE;
      cfg_size   = 20'd64;
      sw_rd_ptr  = '0;
      repeat (3) @(negedge clk);
      check_val("rst_tready", s_axis_trace_tready, 0);
      check_val("rst_awvalid", m_axi_awvalid, 0);
      check_val("rst_wvalid", m_axi_wvalid, 0);
      check_val("rst_bready", m_axi_bready, 0);
      check_val("rst_wr_ptr", sts_wr_ptr, 0);
      check_val("rst_drop", sts_drop_cnt, 0);
      check_val("rst_err", sts_err, 0);
      check_val("rst_busy", sts_busy, 0);

      // Two full bursts, then a 5-beat tlast flush.
      do_reset(20'd64);
      for (int i = 0; i < 32; i++) send_beat(1'b0, 1'b1);
      wait_idle();
      check_val("t1_bursts", len_q.size(), 2);
      check_val("t1_len0", len_q[0], 15);
      check_val("t1_len1", len_q[1], 15);
      check_val("t1_wr_ptr", sts_wr_ptr, 32);
      for (int i = 0; i < 5; i++) send_beat(i == 4, 1'b1);
      wait_idle();
      check_val("t2_bursts", len_q.size(), 3);
      check_val("t2_len", len_q[2], 4);
      check_val("t2_wr_ptr", sts_wr_ptr, 37);

`ifdef TRACE_DROP_ON_FULL_EN
      // Ring blocked: FIFO absorbs 32 beats, the remaining 8 are dropped.
      do_reset(20'd32);
      for (int i = 0; i < 16; i++) send_beat(1'b0, 1'b1);
      wait_idle();
      check_val("t4_wr_ptr", sts_wr_ptr, 16);
      for (int i = 0; i < 40; i++) send_beat(1'b0, i < 32);
      repeat (5) @(negedge clk);
      check_val("t4_tready", s_axis_trace_tready, 1);
      check_val("t4_drop", sts_drop_cnt, 8);
      sw_rd_ptr = 20'd16;
      repeat (60) @(negedge clk);
      sw_rd_ptr = 20'd0;
      wait_idle();
      check_val("t4_wr_final", sts_wr_ptr, 16);
      check_val("t4_drop_final", sts_drop_cnt, 8);
`else
      // Ring of 32: one burst fits, the FIFO fills and backpressure holds.
      do_reset(20'd32);
      for (int i = 0; i < 48; i++) send_beat(1'b0, 1'b1);
      repeat (40) @(negedge clk);
      check_val("t3_wr_ptr", sts_wr_ptr, 16);
      check_val("t3_tready_low", s_axis_trace_tready, 0);
      check_val("t3_bursts", len_q.size(), 1);
      sw_rd_ptr = 20'd16;
      repeat (60) @(negedge clk);
      check_val("t3_wrap", sts_wr_ptr, 0);
      check_val("t3_tready_high", s_axis_trace_tready, 1);
      sw_rd_ptr = 20'd0;
      wait_idle();
      check_val("t3_wr_final", sts_wr_ptr, 16);
      check_val("t3_bursts_final", len_q.size(), 3);
      check_val("t3_drop", sts_drop_cnt, 0);
`endif

      // SLVERR on the second burst: sticky error, pointer still advances.
      do_reset(20'd64);
      err_at = 1;
      for (int i = 0; i < 32; i++) send_beat(1'b0, 1'b1);
      wait_idle();
      err_at = -1;
      check_val("t5_err", sts_err, 1);
      check_val("t5_wr_ptr", sts_wr_ptr, 32);

      // Random stalls with software draining behind the writer.
      do_reset(20'd64);
      check_val("t6_err_cleared", sts_err, 0);
      auto_drain = 1'b1;
`ifdef TRACE_DROP_ON_FULL_EN
      stall_en = 1'b0;
`else
      stall_en = 1'b1;
`endif
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send_beat((i == 999) || ($urandom_range(0, 24) == 0), 1'b1);
      end
      wait_idle();
      stall_en   = 1'b0;
      auto_drain = 1'b0;
      check_val("t6_wr_ptr", sts_wr_ptr, 1000 % 64);
      check_val("t6_sb_empty", exp_q.size(), 0);
      check_val("t6_drop", sts_drop_cnt, 0);
      check_val("t6_err", sts_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
